slc3_button_conditioner: RTL



---
 rtl/slc3_button_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/slc3_button_conditioner.sv
// Run/Continue push-button conditioner: 2-flop sync, counter debounce, press pulses, and an
// optional both-held combo reset (enabled by defining BTN_COMBO_RESET_EN).
module slc3_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_STRETCH   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_raw,
  input  logic       Continue_raw,
  output logic       Run_level,
  output logic       Continue_level,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic       Cpu_reset_h,
  output logic [1:0] Dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COMBO = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || RESET_STRETCH < 1) begin : g_param_check
    $error("slc3_button_conditioner: DEBOUNCE_CYCLES must be >= 2, RESET_STRETCH >= 1");
  end

  // Bit 0 is Run, bit 1 is Continue throughout.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [1:0]    r_level;
  logic [1:0]    r_level_d;
  logic [1:0]    r_pulse;
  logic [CW-1:0] r_cnt [2];
  logic          r_cpu_reset;
  logic          w_pulse_en;
  logic [1:0]    w_rise;

  assign w_rise = r_level & ~r_level_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_stable  <= 2'b11;
      r_level   <= 2'b00;
      r_level_d <= 2'b00;
      r_pulse   <= 2'b00;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
    end else begin
      r_sync1 <= {Continue_raw, Run_raw};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        // Counter only runs while the input disagrees, so it stops at CNT_LAST and never wraps.
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_level   <= ~r_stable;
      r_level_d <= r_level;
      r_pulse   <= w_rise & {2{w_pulse_en}};
    end
  end

`ifdef BTN_COMBO_RESET_EN
  localparam int SW = $clog2(RESET_STRETCH + 1);
  localparam logic [SW-1:0] STRETCH_MAX = SW'(RESET_STRETCH);

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_stretch;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (&r_level) w_state_next = ST_COMBO;
      ST_COMBO: if (r_stretch >= STRETCH_MAX && !(&r_level)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (r_level == 2'b00) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_stretch   <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_cpu_reset <= (r_state == ST_COMBO);
      if (r_state != ST_COMBO) begin
        r_stretch <= '0;
      end else if (r_stretch != STRETCH_MAX) begin
        r_stretch <= r_stretch + 1'b1;
      end
    end
  end

  // A simultaneous rise of both levels goes straight to COMBO without a pulse.
  assign w_pulse_en = (r_state == ST_IDLE) && !(&r_level);
  assign Dbg_state  = r_state;
`else
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cpu_reset <= 1'b1;
    end else begin
      r_cpu_reset <= 1'b0;
    end
  end

  assign w_pulse_en = 1'b1;
  assign Dbg_state  = ST_IDLE;
`endif

  assign Run_level      = r_level[0];
  assign Continue_level = r_level[1];
  assign Run_pulse      = r_pulse[0];
  assign Continue_pulse = r_pulse[1];
  assign Cpu_reset_h    = r_cpu_reset;

endmodule
